// File: rtl/apa102_pkg.sv
// Shared constants and state encoding for the APA102 frame builder.
package apa102_pkg;

    // Fixed APA102 framing bytes
    localparam logic [7:0] START_BYTE  = 8'h00;
    localparam logic [7:0] END_BYTE    = 8'hFF;
    localparam logic [2:0] HDR_MARK    = 3'b111;
    localparam int         START_BYTES = 4;

    // FSM state encoding
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE       = 4'd0;
    localparam state_t ST_START      = 4'd1;
    localparam state_t ST_FETCH_ADDR = 4'd2;
    localparam state_t ST_FETCH_CAP  = 4'd3;
    localparam state_t ST_HDR        = 4'd4;
    localparam state_t ST_BLUE       = 4'd5;
    localparam state_t ST_GREEN      = 4'd6;
    localparam state_t ST_RED        = 4'd7;
    localparam state_t ST_END        = 4'd8;

    // Larger of two integers, used to size the shared byte counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apa102_frame_builder.sv
// APA102 frame builder: reads one RGB word per LED from a synchronous pixel
// RAM and streams start frame, LED frames and end frame as bytes.
//
// Byte handshake: a byte moves on any rising edge where byteValid and
// byteReady are both high. While byteValid is high and byteReady is low,
// byteData holds its value and byteValid stays high; byteReady has no
// effect while byteValid is low.
module apa102_frame_builder
    import apa102_pkg::*;
#(
    parameter int LED_COUNT  = 62,
    parameter int ADDR_WIDTH = 6,
    parameter int END_BYTES  = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [4:0]            brightness,
    output logic [ADDR_WIDTH-1:0] pixAddr,
    output logic                  pixRead,
    input  logic [23:0]           pixData,
    output logic [7:0]            byteData,
    output logic                  byteValid,
    input  logic                  byteReady,
    output logic                  busy,
    output logic                  frameDone,
    output logic [3:0]            stateDbg
);

    // The byte counter serves both the start run and the end run
    localparam int CNT_MAX = max_int(START_BYTES, END_BYTES);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]      START_LAST = CNT_W'(START_BYTES - 1);
    localparam logic [CNT_W-1:0]      END_LAST   = CNT_W'(END_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_LED   = ADDR_WIDTH'(LED_COUNT - 1);

    state_t                  state;
    logic [CNT_W-1:0]        byteCnt;
    logic [ADDR_WIDTH-1:0]   ledIdx;
    logic [4:0]              briHold;
    logic [7:0]              redHold;
    logic [7:0]              greenHold;
    logic [7:0]              blueHold;
    logic                    xfer;

    assign xfer     = byteValid & byteReady;
    assign stateDbg = state;

    // Frame sequencing with registered byte, strobe and status outputs
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            byteCnt   <= '0;
            ledIdx    <= '0;
            briHold   <= '0;
            redHold   <= '0;
            greenHold <= '0;
            blueHold  <= '0;
            pixAddr   <= '0;
            pixRead   <= 1'b0;
            byteData  <= START_BYTE;
            byteValid <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        briHold   <= brightness;
                        byteCnt   <= '0;
                        ledIdx    <= '0;
                        busy      <= 1'b1;
                        byteData  <= START_BYTE;
                        byteValid <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (xfer) begin
                        if (byteCnt == START_LAST) begin
                            byteCnt   <= '0;
                            byteValid <= 1'b0;
                            pixRead   <= 1'b1;
                            pixAddr   <= ledIdx;
                            state     <= ST_FETCH_ADDR;
                        end else begin
                            byteCnt <= byteCnt + CNT_W'(1);
                        end
                    end
                end
                ST_FETCH_ADDR: begin
                    // RAM registers the address on this edge
                    pixRead <= 1'b0;
                    state   <= ST_FETCH_CAP;
                end
                ST_FETCH_CAP: begin
                    redHold   <= pixData[23:16];
                    greenHold <= pixData[15:8];
                    blueHold  <= pixData[7:0];
                    byteData  <= {HDR_MARK, briHold};
                    byteValid <= 1'b1;
                    state     <= ST_HDR;
                end
                ST_HDR: begin
                    if (xfer) begin
                        byteData <= blueHold;
                        state    <= ST_BLUE;
                    end
                end
                ST_BLUE: begin
                    if (xfer) begin
                        byteData <= greenHold;
                        state    <= ST_GREEN;
                    end
                end
                ST_GREEN: begin
                    if (xfer) begin
                        byteData <= redHold;
                        state    <= ST_RED;
                    end
                end
                ST_RED: begin
                    if (xfer) begin
                        if (ledIdx == LAST_LED) begin
                            byteCnt  <= '0;
                            byteData <= END_BYTE;
                            state    <= ST_END;
                        end else begin
                            ledIdx    <= ledIdx + ADDR_WIDTH'(1);
                            pixAddr   <= ledIdx + ADDR_WIDTH'(1);
                            pixRead   <= 1'b1;
                            byteValid <= 1'b0;
                            state     <= ST_FETCH_ADDR;
                        end
                    end
                end
                ST_END: begin
                    if (xfer) begin
                        if (byteCnt == END_LAST) begin
                            byteCnt   <= '0;
                            byteValid <= 1'b0;
                            byteData  <= START_BYTE;
                            busy      <= 1'b0;
                            frameDone <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            byteCnt <= byteCnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apa102_frame_builder.sv
// Bench for apa102_frame_builder: a 2-LED instance for the handshake and
// corner sequences, and a default 62-LED instance for full-length frames.
module tb_apa102_frame_builder;

    logic clock = 1'b0;
    logic resetN;

    // 2-LED instance
    logic        startA;
    logic [4:0]  briA;
    logic [5:0]  pixAddrA;
    logic        pixReadA;
    logic [23:0] pixDataA = '0;
    logic [7:0]  byteDataA;
    logic        byteValidA;
    logic        byteReadyA;
    logic        busyA;
    logic        frameDoneA;
    logic [3:0]  stateA;

    // 62-LED instance
    logic        startB;
    logic [4:0]  briB;
    logic [5:0]  pixAddrB;
    logic        pixReadB;
    logic [23:0] pixDataB = '0;
    logic [7:0]  byteDataB;
    logic        byteValidB;
    logic        byteReadyB;
    logic        busyB;
    logic        frameDoneB;
    logic [3:0]  stateB;

    int checks   = 0;
    int failures = 0;

    logic [23:0] ramA [64];
    logic [23:0] ramB [64];
    logic [7:0]  exp_q  [$];
    logic [7:0]  gotA_q [$];
    logic [7:0]  gotB_q [$];
    int          addrB_q [$];
    int          doneA = 0;
    int          doneB = 0;
    bit          rdyRandom = 1'b0;

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        logic [4:0]  bri;
        bit          rnd_ready;
        int          exp_cycles;  // 0 = not checked (stalled stream)
        logic [7:0]  exp_hdr;
    } vec_t;

    vec_t vecs [6];

    apa102_frame_builder #(.LED_COUNT(2), .ADDR_WIDTH(6), .END_BYTES(4)) dut_a (
        .clock(clock), .resetN(resetN), .start(startA), .brightness(briA),
        .pixAddr(pixAddrA), .pixRead(pixReadA), .pixData(pixDataA),
        .byteData(byteDataA), .byteValid(byteValidA), .byteReady(byteReadyA),
        .busy(busyA), .frameDone(frameDoneA), .stateDbg(stateA)
    );

    apa102_frame_builder dut_b (
        .clock(clock), .resetN(resetN), .start(startB), .brightness(briB),
        .pixAddr(pixAddrB), .pixRead(pixReadB), .pixData(pixDataB),
        .byteData(byteDataB), .byteValid(byteValidB), .byteReady(byteReadyB),
        .busy(busyB), .frameDone(frameDoneB), .stateDbg(stateB)
    );

    // Clock
    always #5 clock = ~clock;

    // Synchronous-read pixel RAM models, one-cycle latency
    always @(posedge clock) begin
        if (pixReadA) pixDataA <= ramA[pixAddrA];
        if (pixReadB) pixDataB <= ramB[pixAddrB];
    end

    // byteReady driver for the 2-LED instance
    initial begin
        byteReadyA = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            byteReadyA = rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: collect transfers, frameDone pulses, RAM reads; check stall stability
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clock);
            if (byteValidA && byteReadyA) gotA_q.push_back(byteDataA);
            if (byteValidB && byteReadyB) gotB_q.push_back(byteDataB);
            if (frameDoneA) doneA++;
            if (frameDoneB) doneB++;
            if (pixReadB) addrB_q.push_back(int'(pixAddrB));
            if (resetN && pv && !pr) begin
                checks++;
                if (!(byteValidA && byteDataA == pd)) begin
                    failures++;
                    $display("FAIL stall_hold actual=valid%0d/%0h expected=valid1/%0h",
                             byteValidA, byteDataA, pd);
                end
            end
            pv = byteValidA && resetN;
            pr = byteReadyA;
            pd = byteDataA;
        end
    end

    // Reference frame: 4 zero bytes, per LED {111,bri} B G R, 4 x 0xFF
    task automatic build_exp(input int which, input int n, input logic [4:0] bri);
        logic [23:0] px;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            px = (which == 0) ? ramA[i] : ramB[i];
            exp_q.push_back(8'(224 + int'(bri)));
            exp_q.push_back(8'(px % 256));
            exp_q.push_back(8'((px / 256) % 256));
            exp_q.push_back(8'(px / 65536));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    endtask

    task automatic compare_stream(input string name, input int which);
        logic [7:0] got [$];
        int bad;
        if (which == 0) got = gotA_q; else got = gotB_q;
        check({name, "_len"}, got.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got[i] !== exp_q[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_byte%0d actual=%0h expected=%0h", name, bad, got[bad], exp_q[bad]);
        end
    endtask

    // Runs one frame; cyc counts edges from the start cycle to frameDone high
    task automatic run_frame(input int which, input logic [4:0] bri, input int mid_start,
                             input int bri_at, input logic [4:0] bri_new, output int cyc);
        logic fd;
        gotA_q.delete();
        gotB_q.delete();
        addrB_q.delete();
        doneA = 0;
        doneB = 0;
        fd = 1'b0;
        cyc = 0;
        @(posedge clock);
        #1;
        if (which == 0) begin startA = 1'b1; briA = bri; end
        else            begin startB = 1'b1; briB = bri; end
        for (int c = 0; c < 5000; c++) begin
            @(posedge clock);
            cyc++;
            #1;
            if (which == 0) startA = (cyc == mid_start);
            else            startB = 1'b0;
            if (cyc == bri_at) begin
                if (which == 0) briA = bri_new; else briB = bri_new;
            end
            fd = (which == 0) ? frameDoneA : frameDoneB;
            if (fd) break;
        end
        startA = 1'b0;
        startB = 1'b0;
        check("frame_done_seen", fd, 1);
        repeat (20) @(posedge clock);
        #1;
    endtask

    initial begin
        int cyc;
        int bad;
        logic [4:0] br;

        startA = 1'b0; briA = '0;
        startB = 1'b0; briB = '0;
        byteReadyB = 1'b1;
        resetN = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ramA[i] = '0;
            ramB[i] = 24'($urandom);
        end

        // Reset state
        #12;
        check("rst_valid_a", byteValidA, 0);
        check("rst_busy_a", busyA, 0);
        check("rst_done_a", frameDoneA, 0);
        check("rst_read_a", pixReadA, 0);
        check("rst_addr_a", pixAddrA, 0);
        check("rst_data_a", byteDataA, 0);
        check("rst_valid_b", byteValidB, 0);
        check("rst_busy_b", busyB, 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (2) @(posedge clock);

        // Vector table
        vecs[0] = '{24'h112233, 24'h445566, 5'h1F, 1'b0, 21, 8'hFF};
        vecs[1] = '{24'h112233, 24'h445566, 5'h1F, 1'b1, 0,  8'hFF};
        vecs[2] = '{24'h000000, 24'hFFFFFF, 5'h00, 1'b0, 21, 8'hE0};
        for (int i = 3; i < 6; i++) begin
            br = 5'($urandom_range(0, 31));
            vecs[i] = '{24'($urandom), 24'($urandom), br, (i % 2 == 1), 0, 8'hE0 | {3'b000, br}};
            if (i % 2 == 0) vecs[i].exp_cycles = 21;
        end

        for (int v = 0; v < 6; v++) begin
            ramA[0] = vecs[v].p0;
            ramA[1] = vecs[v].p1;
            rdyRandom = vecs[v].rnd_ready;
            build_exp(0, 2, vecs[v].bri);
            run_frame(0, vecs[v].bri, -1, -1, vecs[v].bri, cyc);
            compare_stream($sformatf("vec%0d_stream", v), 0);
            check($sformatf("vec%0d_hdr", v), gotA_q.size() > 4 ? gotA_q[4] : 8'hXX, vecs[v].exp_hdr);
            check($sformatf("vec%0d_done_cnt", v), doneA, 1);
            check($sformatf("vec%0d_busy_after", v), busyA, 0);
            if (vecs[v].exp_cycles != 0)
                check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
        end

        // start pulsed while busy: single unchanged frame
        ramA[0] = 24'h112233;
        ramA[1] = 24'h445566;
        rdyRandom = 1'b1;
        build_exp(0, 2, 5'h1F);
        run_frame(0, 5'h1F, 6, -1, 5'h1F, cyc);
        repeat (30) @(posedge clock);
        #1;
        compare_stream("midstart_stream", 0);
        check("midstart_done_cnt", doneA, 1);
        check("midstart_busy", busyA, 0);

        // brightness changed mid-frame: this frame F0, next frame E1
        rdyRandom = 1'b0;
        build_exp(0, 2, 5'h10);
        run_frame(0, 5'h10, -1, 3, 5'h01, cyc);
        compare_stream("bri_old_stream", 0);
        check("bri_old_hdr2", gotA_q.size() > 8 ? gotA_q[8] : 8'hXX, 8'hF0);
        build_exp(0, 2, 5'h01);
        run_frame(0, 5'h01, -1, -1, 5'h01, cyc);
        compare_stream("bri_new_stream", 0);
        check("bri_new_hdr", gotA_q.size() > 4 ? gotA_q[4] : 8'hXX, 8'hE1);

        // reset during the GREEN byte of LED 0
        rdyRandom = 1'b0;
        doneA = 0;
        @(posedge clock);
        #1;
        startA = 1'b1;
        briA = 5'h1F;
        @(posedge clock);
        #1;
        startA = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("rst_mid_green_byte", {byteValidA, byteDataA}, {1'b1, 8'h22});
        resetN = 1'b0;
        #1;
        check("rst_mid_valid", byteValidA, 0);
        check("rst_mid_busy", busyA, 0);
        check("rst_mid_read", pixReadA, 0);
        #3;
        resetN = 1'b1;
        repeat (3) @(posedge clock);
        check("rst_mid_no_done", doneA, 0);
        build_exp(0, 2, 5'h1F);
        run_frame(0, 5'h1F, -1, -1, 5'h1F, cyc);
        compare_stream("rst_after_stream", 0);
        check("rst_after_cycles", cyc, 21);
        check("rst_after_done_cnt", doneA, 1);

        // Default 62-LED frame, byteReady held high
        br = 5'($urandom_range(0, 31));
        build_exp(1, 62, br);
        run_frame(1, br, -1, -1, br, cyc);
        compare_stream("full_stream", 1);
        check("full_len", gotB_q.size(), 256);
        check("full_cycles", cyc, 381);
        check("full_done_cnt", doneB, 1);
        check("full_reads", addrB_q.size(), 62);
        bad = -1;
        for (int i = 0; i < addrB_q.size(); i++) begin
            if (bad < 0 && addrB_q[i] != i) bad = i;
        end
        check("full_addr_seq_first_bad", bad, -1);
        check("full_last_byte", gotB_q.size() > 0 ? gotB_q[gotB_q.size() - 1] : 8'hXX, 8'hFF);
        check("full_busy_after", busyB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
